// File: rtl/uart_pkg.sv
// Shared encodings for the UART receive path: FSM states, parity modes
// and the 3-sample majority helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_BRKWAIT = 3'd5
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level signal,
// with a configurable reset value shared by every stage.
module synchronizer #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: majority-voted bits, optional parity, 1-2 stop
// bits, framing/parity/break/overrun reporting and a valid/ready holding register.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 27,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_main,
    input  logic                 rst_n_main,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int CW = $clog2(DATA_BITS + 1);

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [SW-1:0] S_SAMP0   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_SAMP1   = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_VOTE    = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

    state_t r_state, w_state_nxt;

    logic                 w_rx_s;
    logic                 r_rx_prev;
    logic [2:0]           r_warm;
    logic [BW-1:0]        r_baud;
    logic [SW-1:0]        r_scnt;
    logic [CW-1:0]        r_bcnt;
    logic [1:0]           r_samp;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_par_vote;
    logic                 r_fe_acc;
    logic                 r_stop_hi;

    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;
    logic                 r_break_det;

    logic w_fall, w_tick, w_vote_tick, w_bit_end, w_vote;
    logic w_last_stop, w_is_break, w_fe_final, w_par_exp;

    synchronizer #(
        .STAGES    (2),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .i_clk   (clk_main),
        .i_rst_n (rst_n_main),
        .i_d     (rx_i),
        .o_q     (w_rx_s)
    );

    // Edges are only trusted once the synchronizer's reset value has flushed,
    // so a line held low through reset release is not mistaken for a start bit.
    assign w_fall      = r_warm[2] & r_rx_prev & ~w_rx_s;
    assign w_tick      = (r_baud == BAUD_LAST);
    assign w_vote_tick = w_tick && (r_scnt == S_VOTE);
    assign w_bit_end   = w_tick && (r_scnt == S_LAST);
    assign w_vote      = maj3(r_samp[0], r_samp[1], w_rx_s);
    assign w_last_stop = (r_state == ST_STOP) && w_vote_tick && (r_bcnt == STOP_LAST);
    assign w_is_break  = (r_shift == '0) && ((PARITY == PAR_NONE) || !r_par_vote)
                         && !r_stop_hi && !w_vote;
    assign w_fe_final  = r_fe_acc | ~w_vote;
    assign w_par_exp   = (^r_shift) ^ (PARITY == PAR_ODD);

    always_ff @(posedge clk_main or negedge rst_n_main) begin
        if (!rst_n_main) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_fall) w_state_nxt = ST_START;
            ST_START: begin
                if (w_vote_tick && w_vote) w_state_nxt = ST_IDLE;
                else if (w_bit_end)        w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_end && (r_bcnt == DATA_LAST))
                    w_state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY:  if (w_bit_end) w_state_nxt = ST_STOP;
            ST_STOP:    if (w_last_stop) w_state_nxt = w_is_break ? ST_BRKWAIT : ST_IDLE;
            ST_BRKWAIT: if (w_rx_s) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_main or negedge rst_n_main) begin
        if (!rst_n_main) begin
            r_rx_prev <= 1'b0;
            r_warm    <= '0;
            r_baud    <= '0;
            r_scnt    <= '0;
            r_bcnt    <= '0;
            r_samp    <= '0;
        end else begin
            r_rx_prev <= w_rx_s;
            r_warm    <= {r_warm[1:0], 1'b1};

            if ((r_state == ST_IDLE && w_fall) || w_tick) r_baud <= '0;
            else                                          r_baud <= r_baud + 1'b1;

            if (r_state == ST_IDLE || r_state == ST_BRKWAIT) r_scnt <= '0;
            else if (w_tick) r_scnt <= (r_scnt == S_LAST) ? '0 : r_scnt + 1'b1;

            if (w_tick && r_scnt == S_SAMP0) r_samp[0] <= w_rx_s;
            if (w_tick && r_scnt == S_SAMP1) r_samp[1] <= w_rx_s;

            if (w_state_nxt != r_state) r_bcnt <= '0;
            else if (w_vote_tick && (r_state == ST_DATA || r_state == ST_STOP))
                r_bcnt <= r_bcnt + 1'b1;
        end
    end

    always_ff @(posedge clk_main or negedge rst_n_main) begin
        if (!rst_n_main) begin
            r_shift    <= '0;
            r_par_err  <= 1'b0;
            r_par_vote <= 1'b0;
            r_fe_acc   <= 1'b0;
            r_stop_hi  <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_fall) begin
                r_fe_acc  <= 1'b0;
                r_stop_hi <= 1'b0;
            end
            if (w_vote_tick) begin
                case (r_state)
                    ST_DATA:   r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                    ST_PARITY: begin
                        r_par_vote <= w_vote;
                        r_par_err  <= w_vote ^ w_par_exp;
                    end
                    ST_STOP: begin
                        r_fe_acc  <= r_fe_acc | ~w_vote;
                        r_stop_hi <= r_stop_hi | w_vote;
                    end
                    default: ;
                endcase
            end
        end
    end

    // A delivery in the same cycle as a handshake wins, keeping rx_valid high.
    always_ff @(posedge clk_main or negedge rst_n_main) begin
        if (!rst_n_main) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
            r_break_det  <= 1'b0;
        end else begin
            r_overrun   <= 1'b0;
            r_break_det <= 1'b0;
            if (w_last_stop && w_is_break) begin
                r_break_det <= 1'b1;
                if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;
            end else if (w_last_stop) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data    <= r_shift;
                    r_frame_err  <= w_fe_final;
                    r_parity_err <= r_par_err;
                    r_rx_valid   <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign break_det  = r_break_det;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised single-clock UART receiver: oversampled start-bit validation, 3-sample majority voting, configurable data width, parity and stop bits, and framing/parity/break/overrun detection. Delivers each received character through a valid/ready holding register. It is the next-generation receive path for the UART interface and feeds a FIFO or a register-file consumer in the `clk_main` domain.

## Interface

- `BAUD_DIV`, 27: `clk_main` cycles per oversample tick (≥2).
- `OVERSAMPLE`, 16: ticks per bit period (even, ≥8).
- `DATA_BITS`, 8: character width (5–9).
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.

Ports:

- `clk_main` in 1: sole clock.
- `rst_n_main` in 1: asynchronous, active-low reset.
- `rx_i` in 1: serial line, asynchronous, idle high.
- `rx_data` out DATA_BITS: received character, LSB first on the wire.
- `rx_valid` out 1: `rx_data` and error flags are valid.
- `rx_ready` in 1: consumer accepts; transfer occurs when `rx_valid && rx_ready`.
- `frame_err` out 1: a stop bit sampled low; qualified by `rx_valid`.
- `parity_err` out 1: parity mismatch; qualified by `rx_valid`; 0 when PARITY=0.
- `overrun` out 1: one-cycle pulse when a character is dropped.
- `break_det` out 1: one-cycle pulse on a break condition.
- `busy` out 1: high in any state other than IDLE.

## Operation

- `rx_i` passes through a 2-flop synchronizer (reset value 1) to give `rx_s`. The FSM also uses `rx_s` delayed by one cycle for edge detection.
- Tick generator: counter `0..BAUD_DIV-1`; `tick` fires at `BAUD_DIV-1`. The counter is forced to 0 when START is entered, aligning phase to the falling edge.
- `scnt` counts ticks `0..OVERSAMPLE-1` within a bit. Majority of `rx_s` is taken at ticks `OVERSAMPLE/2-1`, `/2`, `/2+1`; the bit value is fixed at tick `OVERSAMPLE/2+1`.
- FSM states:
  - IDLE: on falling edge of `rx_s` → START.
  - START: at the mid-bit vote, if the vote is 1 (false start) → IDLE with no flags. At `scnt` wrap → DATA.
  - DATA: shift the vote into an MSB-first register (wire LSB first). After DATA_BITS bits → PARITY if PARITY≠0, else STOP.
  - PARITY: compare the vote with the XOR of the data (even) or its inverse (odd); store the mismatch.
  - STOP: vote per stop bit; any low vote sets the frame error. The last stop bit goes to IDLE at its vote, not at bit end, so a back-to-back start is caught.
  - BRKWAIT: entered instead of delivery when data = 0, parity vote = 0 (if used) and all stop votes are 0. Pulse `break_det`, then wait for `rx_s` = 1 → IDLE.
- Delivery happens at the final stop vote:
  - If `rx_valid` = 0 or `rx_ready` = 1: load `rx_data`, `frame_err`, `parity_err`; set `rx_valid`.
  - Otherwise: keep the old contents, drop the new character, pulse `overrun`.
- `rx_valid` clears on a handshake unless a delivery occurs in the same cycle. Delivery wins and `rx_valid` stays 1.

## Timing

- Reset values: `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `parity_err` = 0, `overrun` = 0, `break_det` = 0, `busy` = 0. FSM = IDLE, all counters 0.
- Reset mid-character aborts immediately; nothing is delivered. After release, a line held low is ignored until a high-to-low edge is seen.
- Latency: falling edge on `rx_i` to IDLE exit is 3 cycles (2 sync + edge register). `rx_valid` rises 1 cycle after the final stop-bit vote tick.
- `rx_valid` holds until accepted. `rx_data` is stable while `rx_valid` = 1.
- `overrun` and `break_det` are registered and high for exactly one cycle.
- Counter widths: `$clog2(BAUD_DIV)`, `$clog2(OVERSAMPLE)`, `$clog2(DATA_BITS+1)`. Wrap is by explicit compare, never by natural overflow.

## Structure

- Shared package `uart_pkg` holds:
  - the state encodings (IDLE, START, DATA, PARITY, STOP, BRKWAIT);
  - the parity-mode constants PAR_NONE/PAR_EVEN/PAR_ODD.
- The existing `synchronizer` is the one sub-module, instantiated for `rx_i`. The tick generator stays inline.

## Test plan

All scenarios use BAUD_DIV=4, OVERSAMPLE=16 (64 clocks per bit).

1. 8N1, send 0xA5 with `rx_ready` held 1 → `rx_data` = 0xA5, one-cycle `rx_valid`, no errors.
2. 8E1, send 0x37 with parity bit 0 → `rx_valid` with `parity_err` = 1. Same with parity bit 1 → `parity_err` = 0. Repeat for 8O1 with the expected values inverted.
3. `rx_i` low for 20 clocks, then high → no `rx_valid`, `busy` returns to 0, next 0x5A is received correctly.
4. `rx_ready` = 0, send 0x11 then 0x22 back-to-back → `rx_data` stays 0x11, `overrun` pulses once at the 0x22 stop vote. Raising `rx_ready` transfers 0x11 and `rx_valid` drops.
5. 8N2, second stop bit low, data 0x80 → `frame_err` = 1 with `rx_data` = 0x80. Line low for 12 bit times → `break_det` pulses once, no `rx_valid`, receiver idles after the line returns high.
6. Assert `rst_n_main` mid-DATA for 1 cycle → all outputs 0 immediately, following 0xC3 received correctly.
